// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback, with a
// timed memory handshake, illegal-instruction trapping and a registered retire pulse.
module multicycle_control #(
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned ALUCTRL_WIDTH = 4,
    parameter int unsigned MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     Zero,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     MemWrite,
    output logic                     AdrSrc,
    output logic                     IRWrite,
    output logic                     PCWrite,
    output logic                     RegWrite,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
    output logic [2:0]               IMMsrc,
    output logic [1:0]               ResultSrc,
    output logic                     instr_done,
    output logic                     trap,
    output logic [1:0]               trap_cause
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [ALUCTRL_WIDTH-1:0] AluAdd   = ALUCTRL_WIDTH'(0);
    localparam logic [ALUCTRL_WIDTH-1:0] AluSub   = ALUCTRL_WIDTH'(1);
    localparam logic [ALUCTRL_WIDTH-1:0] AluAnd   = ALUCTRL_WIDTH'(2);
    localparam logic [ALUCTRL_WIDTH-1:0] AluOr    = ALUCTRL_WIDTH'(3);
    localparam logic [ALUCTRL_WIDTH-1:0] AluXor   = ALUCTRL_WIDTH'(4);
    localparam logic [ALUCTRL_WIDTH-1:0] AluSlt   = ALUCTRL_WIDTH'(5);
    localparam logic [ALUCTRL_WIDTH-1:0] AluSltu  = ALUCTRL_WIDTH'(6);
    localparam logic [ALUCTRL_WIDTH-1:0] AluSll   = ALUCTRL_WIDTH'(7);
    localparam logic [ALUCTRL_WIDTH-1:0] AluSrl   = ALUCTRL_WIDTH'(8);
    localparam logic [ALUCTRL_WIDTH-1:0] AluSra   = ALUCTRL_WIDTH'(9);
    localparam logic [ALUCTRL_WIDTH-1:0] AluPassB = ALUCTRL_WIDTH'(10);

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;
    localparam logic [2:0] ImmJ = 3'd4;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResMdr    = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StLui, StAluWb, StMemAdr, StMemRd,
        StMemWr, StMemWb, StBranch, StJal, StJalr, StJumpLink, StTrap
    } state_e;

    state_e           state_q, state_d, dec_state;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic             done_q, done_d;
    logic [2:0]       dec_imm;
    logic             waiting, timeout, taken;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    function automatic logic [ALUCTRL_WIDTH-1:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    // Opcode/funct legality and DECODE successor; anything unrecognised lands in StTrap.
    always_comb begin
        dec_state = StTrap;
        dec_imm   = ImmI;
        case (opcode)
            OpReg: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_state = StExecR;
                end
            end
            OpImm: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) dec_state = StExecI;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) dec_state = StExecI;
                end else begin
                    dec_state = StExecI;
                end
            end
            OpLoad: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec_state = StMemAdr;
            end
            OpStore: begin
                dec_imm = ImmS;
                if (funct3 <= 3'b010) dec_state = StMemAdr;
            end
            OpBranch: begin
                dec_imm = ImmB;
                if (funct3 != 3'b010 && funct3 != 3'b011) dec_state = StBranch;
            end
            OpJal: begin
                dec_imm   = ImmJ;
                dec_state = StJal;
            end
            OpJalr:  dec_state = StJalr;
            OpLui: begin
                dec_imm   = ImmU;
                dec_state = StLui;
            end
            OpAuipc: begin
                dec_imm   = ImmU;
                dec_state = StAluWb;
            end
            default: dec_state = StTrap;
        endcase
    end

    // bge/bgeu/beq take on Zero, the rest on !Zero.
    assign taken = funct3[2] ? (Zero == funct3[0]) : (Zero != funct3[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            done_q  <= done_d;
        end
    end

    assign waiting = state_q inside {StFetch, StMemRd, StMemWr};
    assign timeout = waiting && !mem_ready && (wait_q == WaitW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                state_d = dec_state;
                if (dec_state == StTrap) cause_d = CauseIllegal;
            end
            StExecR, StExecI, StLui:                   state_d = StAluWb;
            StAluWb, StMemWb, StBranch, StJumpLink:    state_d = StFetch;
            StMemAdr: state_d = opcode[5] ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StJal, StJalr:                             state_d = StJumpLink;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
        if (timeout) begin
            state_d = StTrap;
            cause_d = CauseTimeout;
        end
        trap_d = trap_q | (state_d == StTrap);
        done_d = (state_d == StFetch) &&
                 (state_q inside {StAluWb, StMemWr, StMemWb, StBranch, StJumpLink});
        wait_d = (waiting && !mem_ready && state_d == state_q) ? wait_q + WaitW'(1) : '0;
    end

    // Held quiet while rst is asserted so nothing is enabled during reset.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRs2;
        ALUctrl   = AluAdd;
        IMMsrc    = ImmI;
        ResultSrc = ResAluOut;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    ALUSrcB = SrcBFour;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        ResultSrc = ResAlu;
                    end
                end
                StDecode: begin
                    ALUSrcA = SrcAOldPc;
                    ALUSrcB = SrcBImm;
                    IMMsrc  = dec_imm;
                end
                StExecR: begin
                    ALUSrcA = SrcARs1;
                    ALUctrl = alu_op(funct3, funct7[5]);
                end
                StExecI: begin
                    ALUSrcA = SrcARs1;
                    ALUSrcB = SrcBImm;
                    ALUctrl = alu_op(funct3, funct7[5] && funct3 == 3'b101);
                end
                StLui: begin
                    ALUSrcB = SrcBImm;
                    IMMsrc  = ImmU;
                    ALUctrl = AluPassB;
                end
                StAluWb: RegWrite = 1'b1;
                StMemAdr: begin
                    ALUSrcA = SrcARs1;
                    ALUSrcB = SrcBImm;
                    IMMsrc  = opcode[5] ? ImmS : ImmI;
                end
                StMemRd: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                StMemWr: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                StMemWb: begin
                    RegWrite  = 1'b1;
                    ResultSrc = ResMdr;
                end
                StBranch: begin
                    ALUSrcA = SrcARs1;
                    ALUctrl = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
                    PCWrite = taken;
                end
                StJal: PCWrite = 1'b1;
                StJalr: begin
                    ALUSrcA   = SrcARs1;
                    ALUSrcB   = SrcBImm;
                    PCWrite   = 1'b1;
                    ResultSrc = ResAlu;
                end
                StJumpLink: begin
                    RegWrite  = 1'b1;
                    ResultSrc = ResAlu;
                    ALUSrcB   = SrcBFour;
                end
                default: ;
            endcase
        end
    end

    assign instr_done = done_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each instruction into the
// per-cycle control vectors it should produce, for directed and random instruction streams.
module tb_multicycle_control;

    localparam int Timeout = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, trap_cause;
    logic [3:0] ALUctrl;
    logic [2:0] IMMsrc;
    logic       instr_done, trap;

    multicycle_control #(
        .INSTR_WIDTH  (32),
        .ALUCTRL_WIDTH(4),
        .MEM_TIMEOUT  (Timeout)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .Zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUctrl   (ALUctrl),
        .IMMsrc    (IMMsrc),
        .ResultSrc (ResultSrc),
        .instr_done(instr_done),
        .trap      (trap),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [1:0] res;
    } ctrl_t;

    typedef struct {
        ctrl_t c;
        logic  ready;
    } step_t;

    typedef enum {KR, KI, KLui, KAuipc, KLoad, KStore, KBranch, KJal, KJalr, KIllegal} kind_e;

    ctrl_t obs;
    assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUctrl, IMMsrc, ResultSrc};

    step_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    logic  prev_retired = 1'b0;

    function automatic ctrl_t mk(input logic req, we, adr, irw, pcw, rw,
                                 input logic [1:0] sa, sb, input logic [3:0] alu,
                                 input logic [2:0] imm, input logic [1:0] res);
        return {req, we, adr, irw, pcw, rw, sa, sb, alu, imm, res};
    endfunction

    function automatic void push(input ctrl_t c, input logic r);
        exp_q.push_back('{c, r});
    endfunction

    function automatic kind_e classify(input logic [31:0] w);
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        case (w[6:0])
            7'h33: return ((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                          ? KR : KIllegal;
            7'h13: begin
                if (f3 == 3'd1 && f7 != 7'h00) return KIllegal;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return KIllegal;
                return KI;
            end
            7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? KLoad : KIllegal;
            7'h23: return (f3 <= 3'd2) ? KStore : KIllegal;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? KIllegal : KBranch;
            7'h6f: return KJal;
            7'h67: return KJalr;
            7'h37: return KLui;
            7'h17: return KAuipc;
            default: return KIllegal;
        endcase
    endfunction

    function automatic logic [2:0] imm_ref(input logic [6:0] op);
        case (op)
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h37, 7'h17: return 3'd3;
            7'h6f:        return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    // add sll slt sltu xor srl or and, with the alternate forms sub and sra.
    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8] = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
        if (alt && f3 == 3'd0) return 4'h1;
        if (alt && f3 == 3'd5) return 4'h9;
        return tbl[f3];
    endfunction

    // Fills exp_q with the cycle-by-cycle control vectors; returns expected trap cause (0 = none).
    function automatic int build(input logic [31:0] w, input logic z, input int fw, input int mw);
        kind_e      k = classify(w);
        logic [2:0] f3 = w[14:12];
        logic [3:0] op;
        logic       tk;
        ctrl_t      memv;
        ctrl_t      wb = mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0);
        ctrl_t      link = mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 4'd0, 3'd0, 2'd2);
        exp_q.delete();
        for (int i = 0; i < fw && i < Timeout; i++)
            push(mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 4'd0, 3'd0, 2'd0), 1'b0);
        if (fw >= Timeout) return 2;
        push(mk(1, 0, 0, 1, 1, 0, 2'd0, 2'd2, 4'd0, 3'd0, 2'd2), 1'b1);
        push(mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, imm_ref(w[6:0]), 2'd0), 1'b0);
        case (k)
            KIllegal: return 1;
            KR: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, alu_ref(f3, w[30]), 3'd0, 2'd0), 1'b0);
                push(wb, 1'b0);
            end
            KI: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, alu_ref(f3, f3 == 3'd5 && w[30]), 3'd0,
                        2'd0), 1'b0);
                push(wb, 1'b0);
            end
            KLui: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 4'hA, 3'd3, 2'd0), 1'b0);
                push(wb, 1'b0);
            end
            KAuipc: push(wb, 1'b0);
            KLoad, KStore: begin
                push(mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, (k == KStore) ? 3'd1 : 3'd0, 2'd0),
                     1'b0);
                memv = mk(1, k == KStore, 1, 0, 0, 0, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0);
                for (int i = 0; i < mw && i < Timeout; i++) push(memv, 1'b0);
                if (mw >= Timeout) return 2;
                push(memv, 1'b1);
                if (k == KLoad) push(mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0, 3'd0, 2'd1), 1'b0);
            end
            KBranch: begin
                case (f3)
                    3'd0, 3'd1: op = 4'h1;
                    3'd4, 3'd5: op = 4'h5;
                    default:    op = 4'h6;
                endcase
                tk = (f3 inside {3'd0, 3'd5, 3'd7}) ? z : !z;
                push(mk(0, 0, 0, 0, tk, 0, 2'd2, 2'd0, op, 3'd0, 2'd0), 1'b0);
            end
            KJal: begin
                push(mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0), 1'b0);
                push(link, 1'b0);
            end
            default: begin
                push(mk(0, 0, 0, 0, 1, 0, 2'd2, 2'd1, 4'd0, 3'd0, 2'd2), 1'b0);
                push(link, 1'b0);
            end
        endcase
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_retired = 1'b0;
    endtask

    // Runs one instruction from FETCH; entered and left 1 time unit after a rising edge.
    task automatic run_instr(input logic [31:0] w, input logic z, input int fw, input int mw,
                             input string tag);
        int         cause;
        logic [1:0] want_cause;
        logic       want_done;
        instr = w;
        zero = z;
        cause = build(w, z, fw, mw);
        want_cause = 2'(cause);
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = exp_q[i].ready;
            want_done = (i == 0) ? prev_retired : 1'b0;
            @(negedge clk);
            n_checks++;
            if (obs !== exp_q[i].c) begin
                n_fail++;
                $display("FAIL %s ctrl cyc %0d: got %h want %h (instr %h)", tag, i, obs,
                         exp_q[i].c, w);
            end
            n_checks++;
            if (instr_done !== want_done) begin
                n_fail++;
                $display("FAIL %s instr_done cyc %0d: got %b want %b", tag, i, instr_done,
                         want_done);
            end
            n_checks++;
            if (trap !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early trap cyc %0d: got %b want 0", tag, i, trap);
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        if (cause == 0) begin
            prev_retired = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                mem_ready = i[0];
                @(negedge clk);
                n_checks++;
                if (trap !== 1'b1 || trap_cause !== want_cause) begin
                    n_fail++;
                    $display("FAIL %s trap: got %b/%b want 1/%b", tag, trap, trap_cause,
                             want_cause);
                end
                n_checks++;
                if (obs !== ctrl_t'(0) || instr_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s trap quiet: got %h/%b want 0/0", tag, obs, instr_done);
                end
                @(posedge clk);
                #1;
            end
            do_reset();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== ctrl_t'(0) || trap !== 1'b0 || trap_cause !== 2'b00 || instr_done !== 1'b0)
        begin
            n_fail++;
            $display("FAIL reset outputs: got %h/%b/%b/%b want 0/0/00/0", obs, trap, trap_cause,
                     instr_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 4'd0, 3'd0, 2'd0)) begin
            n_fail++;
            $display("FAIL reset fetch: got %h want fetch vector", obs);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_alu();
        run_instr(32'h002081B3, 1'b0, 0, 0, "add");
        run_instr(32'h402081B3, 1'b0, 0, 0, "sub");
        run_instr(32'h4020D093, 1'b0, 1, 0, "srai");
        run_instr(32'hFFF10093, 1'b0, 0, 0, "addi_neg");
        run_instr(32'h123450B7, 1'b0, 2, 0, "lui");
        run_instr(32'h00001097, 1'b0, 0, 0, "auipc");
    endtask

    task automatic test_mem();
        run_instr(32'h0000A183, 1'b0, 1, 3, "lw_wait3");
        run_instr(32'h0030A023, 1'b0, 0, 2, "sw_wait2");
        run_instr(32'h0000C183, 1'b0, 0, 0, "lbu");
    endtask

    task automatic test_branch_jump();
        run_instr(32'h00208463, 1'b1, 0, 0, "beq_taken");
        run_instr(32'h00209463, 1'b1, 0, 0, "bne_not_taken");
        run_instr(32'h0020C463, 1'b0, 0, 0, "blt_taken");
        run_instr(32'h0020F463, 1'b1, 0, 0, "bgeu_taken");
        run_instr(32'h008000EF, 1'b0, 0, 0, "jal");
        run_instr(32'h000080E7, 1'b0, 0, 0, "jalr");
    endtask

    task automatic test_illegal();
        run_instr(32'h00000000, 1'b0, 0, 0, "opcode0");
        run_instr(32'h0000000F, 1'b0, 0, 0, "fence");
        run_instr(32'h00000073, 1'b0, 0, 0, "ecall");
        run_instr(32'h022081B3, 1'b0, 0, 0, "r_funct7");
        run_instr(32'h4020E1B3, 1'b0, 0, 0, "r_alt_or");
        run_instr(32'h0020A463, 1'b0, 0, 0, "branch_f3_2");
        run_instr(32'h0030B023, 1'b0, 0, 0, "store_f3_3");
    endtask

    task automatic test_timeout();
        run_instr(32'h002081B3, 1'b0, Timeout - 1, 0, "fetch_ready_last");
        run_instr(32'h002081B3, 1'b0, Timeout, 0, "fetch_timeout");
        run_instr(32'h0000A183, 1'b0, 0, Timeout, "memrd_timeout");
        run_instr(32'h0030A023, 1'b0, 0, Timeout - 1, "memwr_ready_last");
        run_instr(32'h0030A023, 1'b0, 0, Timeout, "memwr_timeout");
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_ready = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== ctrl_t'(0)) begin
            n_fail++;
            $display("FAIL midwait rst quiet: got %h want 0", obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (trap !== 1'b0 || obs !== mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 4'd0, 3'd0, 2'd0)) begin
            n_fail++;
            $display("FAIL midwait refetch: got %b/%h want 0/fetch vector", trap, obs);
        end
        @(posedge clk);
        #1;
        prev_retired = 1'b0;
        // One wait cycle already spent above; 14 more puts ready on the last legal cycle.
        run_instr(32'h002081B3, 1'b0, Timeout - 2, 0, "midwait_add");
    endtask

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 3))
            0, 1:    return 7'h00;
            2:       return 7'h20;
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] w;
        for (int n = 0; n < 60; n++) begin
            w = $urandom;
            case ($urandom_range(0, 9))
                0: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
                1: begin w[6:0] = 7'h13; w[31:25] = pick_f7(); end
                2: w[6:0] = 7'h37;
                3: w[6:0] = 7'h17;
                4: w[6:0] = 7'h03;
                5: w[6:0] = 7'h23;
                6: w[6:0] = 7'h63;
                7: w[6:0] = 7'h6f;
                8: w[6:0] = 7'h67;
                default: ;
            endcase
            run_instr(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
